// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - serializes the two issue slots onto the single data-SRAM port
module dmem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_other,
  input  logic        req_en_i1,
  input  logic        req_en_i2,
  input  logic        req_wen_i1,
  input  logic        req_wen_i2,
  input  logic [3:0]  req_sel_i1,
  input  logic [3:0]  req_sel_i2,
  input  logic [31:0] req_addr_i1,
  input  logic [31:0] req_addr_i2,
  input  logic [31:0] req_wdata_i1,
  input  logic [31:0] req_wdata_i2,
  input  logic        except_i1,
  input  logic        except_i2,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic [31:0] rdata_i1,
  output logic [31:0] rdata_i2
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state;
  logic        cap_pending;
  logic        split_r;
  logic [31:0] hold_r;

  logic eff1, eff2;
  logic issue1, issue2;

  // An exception on the older slot also kills the younger slot's access.
  assign eff1 = req_en_i1 & ~except_i1;
  assign eff2 = req_en_i2 & ~except_i2 & ~except_i1;

  always_comb begin
    issue1       = 1'b0;
    issue2       = 1'b0;
    stallreq_mem = 1'b0;
    case (state)
      IDLE: begin
        if (eff1 && eff2) begin
          stallreq_mem = 1'b1;
          issue1       = ~stall_other & ~flush;
        end else if (eff1) begin
          issue1 = ~stall_other & ~flush;
        end else if (eff2) begin
          issue2 = ~stall_other & ~flush;
        end
      end
      SECOND: begin
        stallreq_mem = stall_other;
        issue2       = ~stall_other & ~flush;
      end
      default: begin
        stallreq_mem = 1'b0;
      end
    endcase
  end

  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0;
    data_sram_addr  = 32'b0;
    data_sram_wdata = 32'b0;
    if (issue1) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = req_wen_i1 ? req_sel_i1 : 4'b0;
      data_sram_addr  = req_addr_i1;
      data_sram_wdata = req_wdata_i1;
    end else if (issue2) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = req_wen_i2 ? req_sel_i2 : 4'b0;
      data_sram_addr  = req_addr_i2;
      data_sram_wdata = req_wdata_i2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= IDLE;
      cap_pending <= 1'b0;
      split_r     <= 1'b0;
      hold_r      <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue1 || issue2) split_r <= 1'b0;
          if (issue1 && eff2) begin
            state       <= SECOND;
            cap_pending <= 1'b1;
          end
        end
        SECOND: begin
          // Slot1 read data is only on the bus during the first SECOND cycle.
          if (cap_pending) begin
            hold_r      <= data_sram_rdata;
            cap_pending <= 1'b0;
          end
          if (issue2) begin
            split_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata_i1 = split_r ? hold_r : data_sram_rdata;
  assign rdata_i2 = data_sram_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed and randomized checks of dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush, stall_other;
  logic        req_en_i1, req_en_i2, req_wen_i1, req_wen_i2;
  logic [3:0]  req_sel_i1, req_sel_i2;
  logic [31:0] req_addr_i1, req_addr_i2, req_wdata_i1, req_wdata_i2;
  logic        except_i1, except_i2;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [31:0] data_sram_rdata = 32'h5A5A_0001;
  logic        stallreq_mem;
  logic [31:0] rdata_i1, rdata_i2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } acc_t;
  acc_t exp_q[$];

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_other(stall_other),
    .req_en_i1(req_en_i1), .req_en_i2(req_en_i2),
    .req_wen_i1(req_wen_i1), .req_wen_i2(req_wen_i2),
    .req_sel_i1(req_sel_i1), .req_sel_i2(req_sel_i2),
    .req_addr_i1(req_addr_i1), .req_addr_i2(req_addr_i2),
    .req_wdata_i1(req_wdata_i1), .req_wdata_i2(req_wdata_i2),
    .except_i1(except_i1), .except_i2(except_i2),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_mem(stallreq_mem),
    .rdata_i1(rdata_i1), .rdata_i2(rdata_i2)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM with one-cycle read latency; read data holds until the next read.
  always @(posedge clk) begin
    if (data_sram_en) begin
      if (|data_sram_wen)
        mem[data_sram_addr[9:2]] <= merge(mem[data_sram_addr[9:2]], data_sram_wdata, data_sram_wen);
      else
        data_sram_rdata <= mem[data_sram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    req_en_i1 = 0; req_en_i2 = 0; req_wen_i1 = 0; req_wen_i2 = 0;
    req_sel_i1 = 0; req_sel_i2 = 0; req_addr_i1 = 0; req_addr_i2 = 0;
    req_wdata_i1 = 0; req_wdata_i2 = 0; except_i1 = 0; except_i2 = 0;
  endtask

  task automatic set_pair(input logic e1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                          input logic e2, input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    req_en_i1 = e1; req_wen_i1 = w1; req_sel_i1 = 4'hF; req_addr_i1 = a1; req_wdata_i1 = d1;
    req_en_i2 = e2; req_wen_i2 = w2; req_sel_i2 = 4'hF; req_addr_i2 = a2; req_wdata_i2 = d2;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  logic        e1, e2, dual, exp_en, exp_stall, advance, done;
  logic [31:0] v1, v2;
  logic        pv_chk1, pv_chk2;
  logic [31:0] pv_v1, pv_v2;
  int          cyc;
  acc_t        a;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1; flush = 0; stall_other = 0;
    clear_req();
    next(); next();
    rst = 0;

    // Reset state
    @(negedge clk);
    chk("rst_en", data_sram_en, 0);
    chk("rst_wen", data_sram_wen, 0);
    chk("rst_addr", data_sram_addr, 0);
    chk("rst_stall", stallreq_mem, 0);
    chk("rst_rdata_i1", rdata_i1, 32'h5A5A_0001);

    // Single load in slot1
    mem[8'h40] = 32'hA5A5_1234;
    next(); set_pair(1, 0, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_en", data_sram_en, 1);
    chk("single_wen", data_sram_wen, 0);
    chk("single_addr", data_sram_addr, 32'h100);
    chk("single_stall", stallreq_mem, 0);
    next(); clear_req();
    @(negedge clk);
    chk("single_rdata_i1", rdata_i1, 32'hA5A5_1234);

    // Load/load pair
    mem[8'h80] = 32'h1111_1111; mem[8'h81] = 32'h2222_2222;
    next(); set_pair(1, 0, 32'h200, 0, 1, 0, 32'h204, 0);
    @(negedge clk);
    chk("ll_n_addr", data_sram_addr, 32'h200);
    chk("ll_n_stall", stallreq_mem, 1);
    next();
    @(negedge clk);
    chk("ll_n1_en", data_sram_en, 1);
    chk("ll_n1_addr", data_sram_addr, 32'h204);
    chk("ll_n1_stall", stallreq_mem, 0);
    next(); clear_req();
    @(negedge clk);
    chk("ll_rdata_i1", rdata_i1, 32'h1111_1111);
    chk("ll_rdata_i2", rdata_i2, 32'h2222_2222);

    // Store/load to the same address
    next(); set_pair(1, 1, 32'h300, 32'hDEAD_BEEF, 1, 0, 32'h300, 0);
    @(negedge clk);
    chk("sl_n_wen", data_sram_wen, 4'hF);
    chk("sl_n_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    next();
    @(negedge clk);
    chk("sl_n1_en", data_sram_en, 1);
    chk("sl_n1_wen", data_sram_wen, 0);
    next(); clear_req();
    @(negedge clk);
    chk("sl_rdata_i2", rdata_i2, 32'hDEAD_BEEF);

    // Older-slot exception kills both accesses
    next(); set_pair(1, 0, 32'h100, 0, 1, 0, 32'h104, 0); except_i1 = 1;
    @(negedge clk);
    chk("exc_en", data_sram_en, 0);
    chk("exc_stall", stallreq_mem, 0);
    next(); except_i1 = 0; stall_other = 1;
    @(negedge clk);
    chk("exc_idle_stall", stallreq_mem, 1);
    chk("exc_idle_en", data_sram_en, 0);

    // Dual load with stall_other held in SECOND
    next(); stall_other = 0; set_pair(1, 0, 32'h200, 0, 1, 0, 32'h204, 0);
    @(negedge clk);
    chk("hold_n_addr", data_sram_addr, 32'h200);
    for (int k = 0; k < 3; k++) begin
      next(); stall_other = 1;
      @(negedge clk);
      chk("hold_held_en", data_sram_en, 0);
      chk("hold_held_stall", stallreq_mem, 1);
    end
    next(); stall_other = 0;
    @(negedge clk);
    chk("hold_issue_addr", data_sram_addr, 32'h204);
    chk("hold_issue_stall", stallreq_mem, 0);
    next(); clear_req();
    @(negedge clk);
    chk("hold_rdata_i1", rdata_i1, 32'h1111_1111);
    chk("hold_rdata_i2", rdata_i2, 32'h2222_2222);

    // Flush in SECOND
    next(); set_pair(1, 0, 32'h200, 0, 1, 0, 32'h204, 0);
    @(negedge clk);
    chk("fl_n_addr", data_sram_addr, 32'h200);
    next(); flush = 1;
    @(negedge clk);
    chk("fl_en", data_sram_en, 0);
    next(); flush = 0; clear_req();
    @(negedge clk);
    chk("fl_stall", stallreq_mem, 0);
    chk("fl_rdata_i1", rdata_i1, 32'h1111_1111);
    next(); set_pair(1, 0, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fl_idle_addr", data_sram_addr, 32'h100);
    next(); clear_req();

    // Randomized pairs against a transaction-level model
    @(negedge clk);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    pv_chk1 = 0; pv_chk2 = 0; pv_v1 = 0; pv_v2 = 0;
    next();
    for (int p = 0; p < 300; p++) begin
      req_en_i1 = $urandom_range(0, 3) != 0; req_en_i2 = $urandom_range(0, 3) != 0;
      req_wen_i1 = $urandom_range(0, 2) == 0; req_wen_i2 = $urandom_range(0, 2) == 0;
      req_sel_i1 = 4'($urandom_range(1, 15)); req_sel_i2 = 4'($urandom_range(1, 15));
      req_addr_i1 = {22'b0, 6'($urandom_range(0, 15)), 2'b0};
      req_addr_i2 = {22'b0, 6'($urandom_range(0, 15)), 2'b0};
      req_wdata_i1 = $urandom; req_wdata_i2 = $urandom;
      except_i1 = $urandom_range(0, 7) == 0; except_i2 = $urandom_range(0, 7) == 0;

      e1 = req_en_i1 & ~except_i1;
      e2 = req_en_i2 & ~except_i2 & ~except_i1;
      dual = e1 & e2;
      exp_q.delete();
      v1 = 0; v2 = 0;
      if (e1) begin
        exp_q.push_back('{req_addr_i1, req_wen_i1 ? req_sel_i1 : 4'b0, req_wdata_i1});
        if (req_wen_i1) ref_mem[req_addr_i1[9:2]] = merge(ref_mem[req_addr_i1[9:2]], req_wdata_i1, req_sel_i1);
        else v1 = ref_mem[req_addr_i1[9:2]];
      end
      if (e2) begin
        exp_q.push_back('{req_addr_i2, req_wen_i2 ? req_sel_i2 : 4'b0, req_wdata_i2});
        if (req_wen_i2) ref_mem[req_addr_i2[9:2]] = merge(ref_mem[req_addr_i2[9:2]], req_wdata_i2, req_sel_i2);
        else v2 = ref_mem[req_addr_i2[9:2]];
      end

      done = 0; cyc = 0;
      while (!done) begin
        stall_other = $urandom_range(0, 3) == 0;
        @(negedge clk);
        if (cyc == 0) begin
          if (pv_chk1) chk("rnd_rdata_i1", rdata_i1, pv_v1);
          if (pv_chk2) chk("rnd_rdata_i2", rdata_i2, pv_v2);
        end
        exp_stall = dual && (exp_q.size() == 2 || (exp_q.size() == 1 && stall_other));
        exp_en = exp_q.size() > 0 && !stall_other;
        chk("rnd_stall", stallreq_mem, exp_stall);
        chk("rnd_en", data_sram_en, exp_en);
        if (data_sram_en && exp_en) begin
          a = exp_q.pop_front();
          chk("rnd_addr", data_sram_addr, a.addr);
          chk("rnd_wen", data_sram_wen, a.wen);
          chk("rnd_wdata", data_sram_wdata, a.wdata);
        end
        advance = !exp_stall && !stall_other;
        next();
        cyc++;
        if (advance) done = 1;
        else if (cyc > 50) begin
          chk("rnd_timeout", 0, 1);
          done = 1;
        end
      end
      pv_chk1 = e1 & ~req_wen_i1; pv_v1 = v1;
      pv_chk2 = e2 & ~req_wen_i2; pv_v2 = v2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
